// File: rtl/apb_uart_tx_fifo_ctrl.sv
// apb_uart_tx_fifo_ctrl: APB-mapped transmit FIFO for a UART core.
// The CPU pushes characters; a small FSM drains them over valid/ready.
module apb_uart_tx_fifo_ctrl #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOAD    = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  logic              access;
  logic              wr_acc;
  logic              rd_acc;
  logic [1:0]        idx;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level;
  logic [7:0]        lvl8;
  logic              empty;
  logic              full;
  logic              tx_en;
  logic              irq_en;
  logic [7:0]        thresh;
  logic              ovf;
  logic              flush;
  logic              tx_wr;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              ovf_clr;
  logic              accept;
  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [GW-1:0]     gap_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_bits;

  // Upper address bits alias; only part of the write word is decoded.
  assign unused_bits = ^{paddr, pwdata};

  assign access  = psel & penable;
  assign wr_acc  = access & pwrite;
  assign rd_acc  = access & ~pwrite;
  assign idx     = paddr[3:2];
  assign level   = wr_ptr - rd_ptr;
  assign lvl8    = 8'(level);
  assign empty   = (level == '0);
  assign full    = (level == PW'(DEPTH));
  assign flush   = wr_acc & (idx == 2'd0) & pwdata[2];
  assign tx_wr   = wr_acc & (idx == 2'd2);
  assign push    = tx_wr & ~full & ~flush;
  assign ovf_set = tx_wr & full & ~flush;
  assign ovf_clr = wr_acc & (idx == 2'd1) & pwdata[2];
  assign pop     = (state == LOAD) & ~flush;
  assign accept  = (state == PRESENT) & tx_ready;
  assign pready  = 1'b1;
  assign pslverr = ovf_set;

  // FIFO storage; no reset needed since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= pwdata[DATA_W-1:0];
  end

  // Read/write pointers; flush rewinds both on the write edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Control and sticky overflow registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_en  <= 1'b0;
      irq_en <= 1'b0;
      thresh <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc && idx == 2'd0) begin
        tx_en  <= pwdata[0];
        irq_en <= pwdata[1];
        thresh <= pwdata[15:8];
      end
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  // Registered read data, captured in the access cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prdata <= '0;
    end else if (rd_acc) begin
      case (idx)
        2'd0:    prdata <= {16'h0, thresh, 6'h0, irq_en, tx_en};
        2'd1:    prdata <= {16'h0, lvl8, 5'h0, ovf, full, empty};
        default: prdata <= '0;
      endcase
    end
  end

  // Drain FSM next state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tx_en & ~empty & ~flush) state_nx = LOAD;
      LOAD:    state_nx = flush ? IDLE : PRESENT;
      PRESENT: if (tx_ready) state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     if (flush || gap_cnt == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, presented character and inter-character gap counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      gap_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (pop) begin
        tx_data  <= mem[rd_ptr[AW-1:0]];
        tx_valid <= 1'b1;
      end else if (accept) begin
        tx_valid <= 1'b0;
      end
      if (accept)
        gap_cnt <= GW'(GL);
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // Level-threshold interrupt, one cycle behind the level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq <= 1'b0;
    else         irq <= irq_en & tx_en & (lvl8 <= thresh);
  end

endmodule
